// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Brief    : Shared state encoding and constants for the fpu_32 arbiter slice.
// Revision : 1.0
// ============================================================================
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam logic [2:0]  FPU_OP_ADD = 3'b000;
    localparam logic [2:0]  FPU_OP_SUB = 3'b001;
    localparam logic [2:0]  FPU_OP_CMP = 3'b010;

    // Quiet NaN returned on a watchdog abort.
    localparam logic [31:0] FPU_QNAN   = 32'h7FC0_0000;

endpackage
`default_nettype wire

// File: rtl/fpu_32_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_32_arbiter_if
// Brief    : Requester and FPU-side signals of the shared fpu_32 arbiter.
// Revision : 1.0
// ============================================================================
interface fpu_32_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [3*N_REQ-1:0]  req_op;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    resp_valid;
    logic [31:0]         resp_data;
    logic                resp_err;
    logic                busy;
    logic                fpu_valid;
    logic [31:0]         fpu_a;
    logic [31:0]         fpu_b;
    logic [2:0]          fpu_op;
    logic                fpu_ready;
    logic                fpu_idle;
    logic [31:0]         fpu_out;

    // Environment side: requesters plus the FPU instance.
    modport master (
        output req_valid, req_a, req_b, req_op, fpu_ready, fpu_idle, fpu_out,
        input  req_ready, resp_valid, resp_data, resp_err, busy,
               fpu_valid, fpu_a, fpu_b, fpu_op
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, req_op, fpu_ready, fpu_idle, fpu_out,
        output req_ready, resp_valid, resp_data, resp_err, busy,
               fpu_valid, fpu_a, fpu_b, fpu_op
    );
endinterface
`default_nettype wire

// File: rtl/fpu_32_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick, searching from last+1 upward.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  wire logic [N-1:0]  req,
    input  wire logic [IW-1:0] last,
    output logic      [N-1:0]  gnt,
    output logic      [IW-1:0] idx
);
    logic          w_found;
    logic [IW-1:0] w_cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(last) + k) % N);
            if (!w_found && req[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/fpu_32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_32_arbiter
// Brief    : Shares one fpu_32 among N_REQ requesters with a hang watchdog.
// Revision : 1.0
// ============================================================================
module fpu_32_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    fpu_32_arbiter_if.slave bus
);
    localparam int            IW          = $clog2(N_REQ);
    localparam int            WW          = $clog2(TIMEOUT);
    localparam logic [WW-1:0] C_WDOG_LAST = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] C_LAST_RST  = IW'(N_REQ - 1);

    arb_state_t       r_state;
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    r_gidx;
    logic [WW-1:0]    r_wdog;
    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_gidx;
    logic             w_grant;
    logic [N_REQ-1:0] w_resp_sel;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req  (bus.req_valid),
        .last (r_last),
        .gnt  (w_gnt),
        .idx  (w_gidx)
    );

    assign w_grant    = (|bus.req_valid) && bus.fpu_idle;
    assign w_resp_sel = N_REQ'(1) << r_gidx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_IDLE;
            r_last         <= C_LAST_RST;
            r_gidx         <= '0;
            r_wdog         <= '0;
            bus.req_ready  <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.fpu_valid  <= 1'b0;
            bus.fpu_a      <= '0;
            bus.fpu_b      <= '0;
            bus.fpu_op     <= '0;
        end else begin
            bus.req_ready  <= '0;
            bus.resp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        bus.fpu_a     <= bus.req_a[32*w_gidx +: 32];
                        bus.fpu_b     <= bus.req_b[32*w_gidx +: 32];
                        bus.fpu_op    <= bus.req_op[3*w_gidx +: 3];
                        bus.req_ready <= w_gnt;
                        bus.fpu_valid <= 1'b1;
                        bus.busy      <= 1'b1;
                        r_wdog        <= '0;
                        r_last        <= w_gidx;
                        r_gidx        <= w_gidx;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A real result takes precedence over a coincident expiry.
                    if (bus.fpu_ready) begin
                        bus.resp_data  <= bus.fpu_out;
                        bus.resp_err   <= 1'b0;
                        bus.resp_valid <= w_resp_sel;
                        bus.fpu_valid  <= 1'b0;
                        r_state        <= ST_RELEASE;
                    end else if (r_wdog == C_WDOG_LAST) begin
                        bus.resp_data  <= FPU_QNAN;
                        bus.resp_err   <= 1'b1;
                        bus.resp_valid <= w_resp_sel;
                        bus.fpu_valid  <= 1'b0;
                        r_state        <= ST_RELEASE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (bus.fpu_idle) begin
                        bus.busy <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    bus.busy      <= 1'b0;
                    bus.fpu_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fpu_32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_32_arbiter
// Brief    : Self-checking bench with an FPU stand-in and round-robin model.
// Revision : 1.0
// ============================================================================
module tb_fpu_32_arbiter;
    import fpu_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fpu_32_arbiter_if #(.N_REQ(N)) bus ();

    fpu_32_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_last;

    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    logic [2:0]  op_c [N];

    // FPU stand-in controls
    int m_lat       = 2;
    bit m_hang      = 1'b0;
    bit m_hold_busy = 1'b0;
    int m_state;
    int m_cnt;

    // Arithmetic stand-in: exact for the 1.0+2.0 case, an arbitrary mix otherwise.
    function automatic logic [31:0] fpu_func(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
        if (op == FPU_OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000)
            return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Level handshake: ready some cycles after valid, idle again after valid drops.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_state       <= 0;
            m_cnt         <= 0;
            bus.fpu_ready <= 1'b0;
            bus.fpu_idle  <= 1'b1;
            bus.fpu_out   <= '0;
        end else begin
            case (m_state)
                0: begin
                    bus.fpu_idle <= !m_hold_busy;
                    if (bus.fpu_valid && bus.fpu_idle) begin
                        m_state      <= 1;
                        m_cnt        <= 0;
                        bus.fpu_idle <= 1'b0;
                        bus.fpu_out  <= fpu_func(bus.fpu_a, bus.fpu_b, bus.fpu_op);
                    end
                end
                1: begin
                    if (!bus.fpu_valid) m_state <= 3;
                    else if (!m_hang) begin
                        if (m_cnt == m_lat) begin
                            bus.fpu_ready <= 1'b1;
                            m_state       <= 2;
                        end else m_cnt <= m_cnt + 1;
                    end
                end
                2: begin
                    if (!bus.fpu_valid) begin
                        bus.fpu_ready <= 1'b0;
                        m_state       <= 3;
                    end
                end
                default: begin
                    bus.fpu_ready <= 1'b0;
                    bus.fpu_idle  <= 1'b1;
                    m_state       <= 0;
                end
            endcase
        end
    end

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_a[32*i +: 32] = op_a[i];
            bus.req_b[32*i +: 32] = op_b[i];
            bus.req_op[3*i +: 3]  = op_c[i];
        end
    endtask

    task automatic new_operands(input int i);
        op_a[i] = $urandom;
        op_b[i] = $urandom;
        op_c[i] = 3'($urandom_range(0, 2));
        drive_ops();
    endtask

    task automatic apply_reset();
        rstn          = 1'b0;
        bus.req_valid = '0;
        m_hang        = 1'b0;
        m_hold_busy   = 1'b0;
        repeat (3) @(negedge clk);
        rstn     = 1'b1;
        exp_last = N - 1;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.busy || !bus.fpu_idle) && n < 200) begin @(negedge clk); n++; end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drain: busy=%b after %0d cycles, required 0", bus.busy, n); end
    endtask

    // Runs one transaction on the pending requests; returns what was observed.
    task automatic run_txn(input bit keep, output int gidx, output int gwait,
                           output logic [31:0] ga, output logic [31:0] gb, output logic [2:0] gop,
                           output int vcyc, output int ridx, output logic [31:0] rdata,
                           output logic rerr, output int xrdy, output bit tmo);
        int n = 0;
        gidx = -1; gwait = 0; vcyc = 0; ridx = -1; rdata = '0; rerr = 1'b0;
        ga = '0; gb = '0; gop = '0; xrdy = 0; tmo = 1'b0;
        do begin @(negedge clk); gwait++; end while (bus.req_ready == '0 && gwait < 300);
        if (bus.req_ready == '0) begin tmo = 1'b1; return; end
        gidx = onehot_idx(bus.req_ready);
        ga = bus.fpu_a; gb = bus.fpu_b; gop = bus.fpu_op;
        if (gidx >= 0) begin
            if (keep) new_operands(gidx);
            else bus.req_valid[gidx] = 1'b0;
        end
        while (bus.resp_valid == '0 && n < 300) begin
            if (bus.fpu_valid) vcyc++;
            @(negedge clk); n++;
            if (bus.req_ready != '0) xrdy++;
        end
        if (bus.resp_valid == '0) begin tmo = 1'b1; return; end
        ridx  = onehot_idx(bus.resp_valid);
        rdata = bus.resp_data;
        rerr  = bus.resp_err;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", bus.req_ready); end
        checks++; if (bus.resp_valid !== '0) begin errors++; $display("FAIL reset_resp_valid: got %b required 0", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h required 0", bus.resp_data); end
        checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b required 0", bus.resp_err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.fpu_valid !== 1'b0) begin errors++; $display("FAIL reset_fpu_valid: got %b required 0", bus.fpu_valid); end
        checks++; if ({bus.fpu_a, bus.fpu_b, bus.fpu_op} !== 67'h0) begin errors++; $display("FAIL reset_operands: got %h/%h/%h required 0", bus.fpu_a, bus.fpu_b, bus.fpu_op); end
    endtask

    task automatic test_single();
        int gidx, gwait, vcyc, ridx, xrdy, eg; logic [31:0] ga, gb, rdata; logic [2:0] gop; logic rerr; bit tmo;
        op_a[2] = 32'h3F80_0000; op_b[2] = 32'h4000_0000; op_c[2] = FPU_OP_ADD;
        drive_ops();
        m_lat = 3;
        bus.req_valid = 4'b0100;
        eg = rr_pick(bus.req_valid, exp_last);
        run_txn(1'b0, gidx, gwait, ga, gb, gop, vcyc, ridx, rdata, rerr, xrdy, tmo);
        exp_last = eg;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL single_timeout: handshake bound expired"); end
        checks++; if (gidx !== eg) begin errors++; $display("FAIL single_grant: got %0d required %0d", gidx, eg); end
        checks++; if ({ga, gb, gop} !== {32'h3F80_0000, 32'h4000_0000, FPU_OP_ADD}) begin errors++; $display("FAIL single_operands: got %h %h %h", ga, gb, gop); end
        checks++; if (xrdy !== 0) begin errors++; $display("FAIL single_ready_pulse: extra ready cycles %0d required 0", xrdy); end
        // FPU stand-in answers lat+2 cycles after valid; response adds one.
        checks++; if (vcyc !== m_lat + 3) begin errors++; $display("FAIL single_valid_hold: got %0d required %0d", vcyc, m_lat + 3); end
        checks++; if (ridx !== 2) begin errors++; $display("FAIL single_resp_idx: got %0d required 2", ridx); end
        checks++; if (rdata !== 32'h4040_0000) begin errors++; $display("FAIL single_resp_data: got %h required 40400000", rdata); end
        checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL single_resp_err: got %b required 0", rerr); end
        drain();
    endtask

    task automatic test_fairness();
        int gidx, gwait, vcyc, ridx, xrdy, eg; logic [31:0] ga, gb, rdata, ea, eb; logic [2:0] gop, eo; logic rerr; bit tmo;
        apply_reset();
        for (int i = 0; i < N; i++) new_operands(i);
        bus.req_valid = '1;
        for (int t = 0; t < 8; t++) begin
            m_lat = $urandom_range(0, 3);
            eg = rr_pick(bus.req_valid, exp_last);
            ea = op_a[eg]; eb = op_b[eg]; eo = op_c[eg];
            run_txn(1'b1, gidx, gwait, ga, gb, gop, vcyc, ridx, rdata, rerr, xrdy, tmo);
            exp_last = eg;
            checks++; if (gidx !== t % N) begin errors++; $display("FAIL fair_order[%0d]: got %0d required %0d", t, gidx, t % N); end
            checks++; if (ridx !== eg || tmo) begin errors++; $display("FAIL fair_resp_idx[%0d]: got %0d required %0d", t, ridx, eg); end
            checks++; if (rdata !== fpu_func(ea, eb, eo) || rerr !== 1'b0) begin errors++; $display("FAIL fair_data[%0d]: got %h/%b required %h/0", t, rdata, rerr, fpu_func(ea, eb, eo)); end
            if (t > 0) begin
                checks++; if (gwait < 2) begin errors++; $display("FAIL fair_spacing[%0d]: got %0d required >=2", t, gwait); end
            end
        end
        bus.req_valid = '0;
        drain();
    endtask

    task automatic test_fpu_not_idle();
        int gidx, gwait, vcyc, ridx, xrdy, eg, seen, n; logic [31:0] ga, gb, rdata, ea, eb; logic [2:0] gop, eo; logic rerr; bit tmo;
        m_hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) new_operands(i);
        bus.req_valid = 4'b1010;
        seen = 0;
        repeat (12) begin @(negedge clk); if (bus.req_ready != '0 || bus.busy) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL notidle_hold: activity cycles %0d required 0", seen); end
        m_hold_busy = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.fpu_idle && n < 10);
        for (int r = 0; r < 2; r++) begin
            m_lat = $urandom_range(0, 4);
            eg = rr_pick(bus.req_valid, exp_last);
            ea = op_a[eg]; eb = op_b[eg]; eo = op_c[eg];
            run_txn(1'b0, gidx, gwait, ga, gb, gop, vcyc, ridx, rdata, rerr, xrdy, tmo);
            exp_last = eg;
            if (r == 0) begin
                checks++; if (gwait !== 1) begin errors++; $display("FAIL notidle_release_grant: waited %0d required 1", gwait); end
            end
            checks++; if (gidx !== eg || ridx !== eg || tmo) begin errors++; $display("FAIL notidle_grant[%0d]: got %0d/%0d required %0d", r, gidx, ridx, eg); end
            checks++; if (rdata !== fpu_func(ea, eb, eo)) begin errors++; $display("FAIL notidle_data[%0d]: got %h required %h", r, rdata, fpu_func(ea, eb, eo)); end
        end
        drain();
    endtask

    task automatic test_timeout();
        int gidx, gwait, vcyc, ridx, xrdy, eg, r, n; logic [31:0] ga, gb, rdata; logic [2:0] gop; logic rerr; bit tmo;
        m_hang = 1'b1;
        r = $urandom_range(0, N - 1);
        new_operands(r);
        bus.req_valid = '0;
        bus.req_valid[r] = 1'b1;
        eg = rr_pick(bus.req_valid, exp_last);
        run_txn(1'b0, gidx, gwait, ga, gb, gop, vcyc, ridx, rdata, rerr, xrdy, tmo);
        exp_last = eg;
        checks++; if (gidx !== eg || ridx !== eg || tmo) begin errors++; $display("FAIL tmo_idx: got %0d/%0d required %0d", gidx, ridx, eg); end
        checks++; if (vcyc !== TMO) begin errors++; $display("FAIL tmo_cycles: got %0d required %0d", vcyc, TMO); end
        checks++; if (rdata !== FPU_QNAN) begin errors++; $display("FAIL tmo_data: got %h required %h", rdata, FPU_QNAN); end
        checks++; if (rerr !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b required 1", rerr); end
        checks++; if (bus.fpu_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL tmo_release: fpu_valid=%b busy=%b required 0/1", bus.fpu_valid, bus.busy); end
        m_hang = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin @(negedge clk); n++; end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_idle_return: busy=%b required 0", bus.busy); end
        checks++; if (bus.resp_data !== FPU_QNAN || bus.resp_err !== 1'b1) begin errors++; $display("FAIL tmo_hold: got %h/%b required %h/1", bus.resp_data, bus.resp_err, FPU_QNAN); end
    endtask

    task automatic test_tie();
        int gidx, gwait, vcyc, ridx, xrdy, eg; logic [31:0] ga, gb, rdata, ea, eb; logic [2:0] gop, eo; logic rerr; bit tmo;
        // lat TMO-3 lands ready on the expiry cycle; TMO-2 is one cycle too late.
        for (int k = 0; k < 2; k++) begin
            m_lat = TMO - 3 + k;
            new_operands(1);
            bus.req_valid = 4'b0010;
            eg = rr_pick(bus.req_valid, exp_last);
            ea = op_a[eg]; eb = op_b[eg]; eo = op_c[eg];
            run_txn(1'b0, gidx, gwait, ga, gb, gop, vcyc, ridx, rdata, rerr, xrdy, tmo);
            exp_last = eg;
            checks++; if (vcyc !== TMO || ridx !== eg || tmo) begin errors++; $display("FAIL tie_cycles[%0d]: got %0d idx %0d required %0d idx %0d", k, vcyc, ridx, TMO, eg); end
            checks++; if (rerr !== (k == 1)) begin errors++; $display("FAIL tie_err[%0d]: got %b required %0d", k, rerr, k); end
            checks++; if (rdata !== ((k == 1) ? FPU_QNAN : fpu_func(ea, eb, eo))) begin errors++; $display("FAIL tie_data[%0d]: got %h", k, rdata); end
            drain();
        end
    endtask

    task automatic test_reset_mid();
        int gidx, gwait, vcyc, ridx, xrdy, eg, n; logic [31:0] ga, gb, rdata, ea, eb; logic [2:0] gop, eo; logic rerr; bit tmo;
        m_hang = 1'b1;
        new_operands(2);
        bus.req_valid = 4'b0100;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.req_ready == '0 && n < 50);
        bus.req_valid = '0;
        repeat (5) @(negedge clk);
        checks++; if (bus.fpu_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: fpu_valid=%b required 1", bus.fpu_valid); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (bus.fpu_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_async: fpu_valid=%b busy=%b required 0/0", bus.fpu_valid, bus.busy); end
        checks++; if ({bus.req_ready, bus.resp_valid, bus.resp_err} !== '0 || bus.resp_data !== 32'h0 || bus.fpu_a !== 32'h0) begin errors++; $display("FAIL rstmid_outputs: rdy=%b rv=%b data=%h a=%h", bus.req_ready, bus.resp_valid, bus.resp_data, bus.fpu_a); end
        m_hang = 1'b0;
        for (int i = 0; i < N; i++) new_operands(i);
        bus.req_valid = '1;
        @(negedge clk);
        rstn = 1'b1;
        exp_last = N - 1;
        for (int t = 0; t < N; t++) begin
            m_lat = $urandom_range(0, 3);
            eg = rr_pick(bus.req_valid, exp_last);
            ea = op_a[eg]; eb = op_b[eg]; eo = op_c[eg];
            run_txn(1'b0, gidx, gwait, ga, gb, gop, vcyc, ridx, rdata, rerr, xrdy, tmo);
            exp_last = eg;
            if (t == 0) begin
                checks++; if (gidx !== 0) begin errors++; $display("FAIL rstmid_first: got %0d required 0", gidx); end
            end
            checks++; if (ridx !== eg || rdata !== fpu_func(ea, eb, eo) || tmo) begin errors++; $display("FAIL rstmid_resp[%0d]: got %0d/%h required %0d/%h", t, ridx, rdata, eg, fpu_func(ea, eb, eo)); end
        end
        drain();
    endtask

    task automatic test_random();
        int gidx, gwait, vcyc, ridx, xrdy, eg; logic [31:0] ga, gb, rdata, ea, eb; logic [2:0] gop, eo; logic rerr; bit tmo;
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < N; i++) new_operands(i);
            m_lat = $urandom_range(0, 6);
            bus.req_valid = N'($urandom_range(1, (1 << N) - 1));
            eg = rr_pick(bus.req_valid, exp_last);
            ea = op_a[eg]; eb = op_b[eg]; eo = op_c[eg];
            run_txn(1'b0, gidx, gwait, ga, gb, gop, vcyc, ridx, rdata, rerr, xrdy, tmo);
            exp_last = eg;
            checks++; if (gidx !== eg || ridx !== eg || tmo) begin errors++; $display("FAIL rand_idx[%0d]: got %0d/%0d required %0d", t, gidx, ridx, eg); end
            checks++; if ({ga, gb, gop} !== {ea, eb, eo}) begin errors++; $display("FAIL rand_operands[%0d]: got %h %h %h required %h %h %h", t, ga, gb, gop, ea, eb, eo); end
            checks++; if (rdata !== fpu_func(ea, eb, eo) || rerr !== 1'b0) begin errors++; $display("FAIL rand_data[%0d]: got %h/%b required %h/0", t, rdata, rerr, fpu_func(ea, eb, eo)); end
        end
        bus.req_valid = '0;
        drain();
    endtask

    initial begin
        rstn          = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; op_c[i] = '0; end
        drive_ops();
        test_reset();
        test_single();
        test_fairness();
        test_fpu_not_idle();
        test_timeout();
        test_tie();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_bound: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/fpu_32_arbiter.md
# fpu_32_arbiter

Round-robin arbiter and sequencer that shares one `fpu_32` instance among `N_REQ` requesters. It accepts one operation at a time from the granted requester and registers its operands. It drives the FPU's level-sensitive valid/ready/idle handshake through a full issue/complete/release cycle and returns the result to the originating requester with a one-cycle response pulse. A watchdog aborts a hung FPU operation with an error response so requesters never deadlock.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: max cycles in ISSUE before abort (≥4).

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester request, level; must hold until `req_ready` pulses.
- `req_a` in 32·N_REQ: operand A, slice i belongs to requester i.
- `req_b` in 32·N_REQ: operand B, slice i belongs to requester i.
- `req_op` in 3·N_REQ: op code, slice i belongs to requester i.
- `req_ready` out N_REQ: one-hot, one-cycle accept pulse.
- `resp_valid` out N_REQ: one-hot, one-cycle result pulse.
- `resp_data` out 32: result, valid when any `resp_valid` bit is set.
- `resp_err` out 1: the pulse is a timeout abort.
- `busy` out 1: state ≠ IDLE.
- `fpu_valid` out 1: to FPU `valid`.
- `fpu_a` out 32: to FPU `a`, registered.
- `fpu_b` out 32: to FPU `b`, registered.
- `fpu_op` out 3: to FPU `op`, registered.
- `fpu_ready` in 1: from FPU `ready`.
- `fpu_idle` in 1: from FPU `idle`.
- `fpu_out` in 32: from FPU `out`.

## Operation
- States: IDLE, ISSUE, RELEASE.
- IDLE: when `|req_valid` and `fpu_idle`, grant winner g (round robin):
  - latch `req_a/b/op[g]` into `fpu_a/b/op`;
  - pulse `req_ready[g]`;
  - set `fpu_valid`=1, clear watchdog, go to ISSUE.
  - If `fpu_idle`=0, no grant.
- ISSUE: `fpu_valid` held at 1 and operands stable.
  - `fpu_ready`=1 → register `fpu_out` into `resp_data`, `resp_err`=0, pulse `resp_valid[g]`, `fpu_valid`←0, go to RELEASE.
  - Watchdog reaches `TIMEOUT`−1 without `fpu_ready` → `resp_data`←32'h7FC00000 (qNaN), `resp_err`=1, pulse `resp_valid[g]`, `fpu_valid`←0, go to RELEASE.
- RELEASE: wait for `fpu_idle`=1, then go to IDLE. No grant in the same cycle.
- Round robin:
  - pointer `last` = last granted index; search starts at `last`+1 mod N_REQ; `last`←g on grant.
  - Reset value `last`=N_REQ−1, so requester 0 has first priority.
  - Requests arriving in non-IDLE states wait. `req_valid` dropped before acceptance is simply not granted; no state is lost.
- Op codes pass through unchanged: 000 add, 001 sub, 010 cmp. The arbiter does not decode them.
- `resp_data`/`resp_err` hold their value until the next response.

## Timing
- Reset: state IDLE, `fpu_valid`=0, `fpu_a/b`=0, `fpu_op`=0, `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `busy`=0, watchdog=0, `last`=N_REQ−1.
- All outputs are registered. `req_ready` pulses in the cycle after the grant decision, together with `fpu_valid` rising.
- Response latency is FPU latency + 1 cycle: `resp_valid` asserts the cycle after `fpu_ready` is sampled high.
- Minimum issue spacing: grant → ISSUE → RELEASE → IDLE. The next grant is ≥2 cycles after `resp_valid`.
- Reset mid-operation: all state clears immediately and `fpu_valid` drops asynchronously. The in-flight operation is lost with no response.
- `fpu_ready` and watchdog expiry in the same cycle: `fpu_ready` wins, `resp_err`=0.

## Structure
- Shared package `fpu_pkg`: state encoding, op code constants (`FPU_OP_ADD/SUB/CMP`), `FPU_QNAN` = 32'h7FC00000.
- Sub-module `rr_arbiter` (parameter N): inputs `req` and `last`; outputs one-hot `gnt` and encoded index. Purely combinational.
- Top level contains the FSM, operand registers, watchdog counter, and response registers.

## Test plan
- Single request: requester 2 sends a=3F800000, b=40000000, op=000 (1.0+2.0) → one `req_ready[2]` pulse, `fpu_valid` held until `fpu_ready`, `resp_valid[2]` with `resp_data`=40400000, `resp_err`=0.
- Fairness: all 4 requesters assert continuously for 8 operations → grant order 0,1,2,3,0,1,2,3. Each `resp_valid` bit matches its grant.
- FPU not idle: hold `fpu_idle`=0 with requests pending → no `req_ready`. Release `fpu_idle` → grant on the next cycle.
- Timeout: FPU model never asserts `fpu_ready` → after TIMEOUT=64 cycles, `resp_valid[g]` with `resp_data`=7FC00000, `resp_err`=1, then `fpu_valid`=0 and a return to IDLE after `fpu_idle`.
- Tie at expiry: `fpu_ready` asserted on the watchdog-expiry cycle → normal response, `resp_err`=0.
- Reset mid-ISSUE: assert `rstn`=0 while `fpu_valid`=1 → all outputs at reset values immediately. After release, requester 0 is served first.
